// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, default text base
// and the word-address helper used by the address generator.
package imem_loader_pkg;

    localparam int          IMEM_WORD_W = 32;
    localparam logic [31:0] TEXT_BASE   = 32'h0040_0020;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte address of word number 'count'; the 32-bit add wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] count);
        return base + {14'd0, count, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU hold/status signals of the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                   load_go;
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;
    logic                   mem_we;
    logic [IMEM_WORD_W-1:0] mem_addr;
    logic [IMEM_WORD_W-1:0] mem_wdata;
    logic                   cpu_hold;
    logic                   load_done;
    logic [15:0]            word_count;

    modport master (
        output load_go, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, word_count
    );

    modport slave (
        input  load_go, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, word_count
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Four-byte shift buffer: the first byte shifted in ends up in bits [31:24] once the
// buffer is full. A clear pulse empties it after the word has been written.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_shift,
    input  logic [7:0]             i_byte,
    output logic                   o_full,
    output logic [IMEM_WORD_W-1:0] o_word
);

    logic [3:0][7:0] r_buf;
    logic [3:0][7:0] w_buf_next;
    logic [1:0]      r_cnt;
    logic            r_full;

    // Lane 0 takes the incoming byte, every other lane takes its lower neighbour.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            if (gi == 0) begin : g_in
                assign w_buf_next[gi] = i_byte;
            end else begin : g_mv
                assign w_buf_next[gi] = r_buf[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf  <= '0;
            r_cnt  <= 2'd0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_buf  <= '0;
            r_cnt  <= 2'd0;
            r_full <= 1'b0;
        end else if (i_shift) begin
            r_buf <= w_buf_next;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_full <= 1'b1;
            end
        end
    end

    assign o_full = r_full;
    assign o_word = r_buf;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as big-endian words starting
// at BASE_ADDR, holding the CPU until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TEXT_BASE,
    parameter int          LEN_BYTES = 2
) (
    input  logic          clk,
    input  logic          start_up,
    imem_loader_if.slave  bus
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [15:0]            r_len;
    logic [15:0]            r_word_count;
    logic [1:0]             r_hdr_cnt;
    logic [IMEM_WORD_W-1:0] r_last_addr;
    logic [IMEM_WORD_W-1:0] r_last_wdata;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_full;
    logic                   w_write;
    logic                   w_hdr_last;
    logic                   w_last_word;
    logic [15:0]            w_len_next;
    logic [IMEM_WORD_W-1:0] w_word;
    logic [IMEM_WORD_W-1:0] w_addr;

    // The cycle in which the packer is full is the write cycle; no byte is taken then.
    assign w_ready     = (r_state == ST_LEN) || ((r_state == ST_LOAD) && !w_full);
    assign w_accept    = w_ready && bus.byte_valid;
    assign w_write     = (r_state == ST_LOAD) && w_full;
    assign w_hdr_last  = (r_hdr_cnt == 2'(LEN_BYTES - 1));
    assign w_len_next  = {r_len[7:0], bus.byte_data};
    assign w_last_word = ((r_word_count + 16'd1) == r_len);
    assign w_addr      = word_addr(BASE_ADDR, r_word_count);

    imem_loader_byte_packer u_packer (
        .clk     (clk),
        .rst     (start_up),
        .i_clear (w_write),
        .i_shift (w_accept && (r_state == ST_LOAD)),
        .i_byte  (bus.byte_data),
        .o_full  (w_full),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or posedge start_up) begin
        if (start_up) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.load_go) begin
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept && w_hdr_last) begin
                    w_state_next = (w_len_next == 16'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_write && w_last_word) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge start_up) begin
        if (start_up) begin
            r_len        <= 16'd0;
            r_hdr_cnt    <= 2'd0;
            r_word_count <= 16'd0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            if ((r_state == ST_LEN) && w_accept) begin
                r_len     <= w_len_next;
                r_hdr_cnt <= r_hdr_cnt + 2'd1;
            end
            if (w_write) begin
                r_word_count <= r_word_count + 16'd1;
                r_last_addr  <= w_addr;
                r_last_wdata <= w_word;
            end
        end
    end

    // Address and data show the live word during a write and hold the last one otherwise.
    assign bus.byte_ready = w_ready;
    assign bus.mem_we     = w_write;
    assign bus.mem_addr   = w_write ? w_addr : r_last_addr;
    assign bus.mem_wdata  = w_write ? w_word : r_last_wdata;
    assign bus.cpu_hold   = (r_state != ST_DONE);
    assign bus.load_done  = (r_state == ST_DONE);
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: expected writes are queued when a load is
// issued and a per-cycle monitor pops and compares every memory write.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam logic [31:0] BASE1 = 32'h0040_0020;
    localparam logic [31:0] BASE2 = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        ready;
        logic        we;
        logic        hold;
        logic        done;
        logic [15:0] wc;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obs_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst2;

    always #5 clk = ~clk;

    imem_loader_if bus1();
    imem_loader_if bus2();

    imem_loader #(.BASE_ADDR(BASE1), .LEN_BYTES(2)) dut1 (
        .clk      (clk),
        .start_up (rst1),
        .bus      (bus1.slave)
    );

    imem_loader #(.BASE_ADDR(BASE2), .LEN_BYTES(2)) dut2 (
        .clk      (clk),
        .start_up (rst2),
        .bus      (bus2.slave)
    );

    wr_t         exp_q1[$];
    wr_t         exp_q2[$];
    logic [31:0] img[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_we[2];
    logic [31:0] last_addr[2];
    logic [31:0] last_data[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic obs_t snap(input bit sel);
        obs_t o;
        if (sel) begin
            o.ready = bus2.byte_ready; o.we = bus2.mem_we; o.hold = bus2.cpu_hold;
            o.done  = bus2.load_done;  o.wc = bus2.word_count;
            o.addr  = bus2.mem_addr;   o.wdata = bus2.mem_wdata;
        end else begin
            o.ready = bus1.byte_ready; o.we = bus1.mem_we; o.hold = bus1.cpu_hold;
            o.done  = bus1.load_done;  o.wc = bus1.word_count;
            o.addr  = bus1.mem_addr;   o.wdata = bus1.mem_wdata;
        end
        return o;
    endfunction

    task automatic drv(input bit sel, input logic go, input logic v, input logic [7:0] d);
        if (sel) begin
            bus2.load_go = go; bus2.byte_valid = v; bus2.byte_data = d;
        end else begin
            bus1.load_go = go; bus1.byte_valid = v; bus1.byte_data = d;
        end
    endtask

    task automatic check_reset_vals(input bit sel);
        obs_t o;
        o = snap(sel);
        check("rst_byte_ready", 32'(o.ready), 32'd0);
        check("rst_mem_we",     32'(o.we),    32'd0);
        check("rst_mem_addr",   o.addr,       32'd0);
        check("rst_mem_wdata",  o.wdata,      32'd0);
        check("rst_load_done",  32'(o.done),  32'd0);
        check("rst_word_count", 32'(o.wc),    32'd0);
        check("rst_cpu_hold",   32'(o.hold),  32'd1);
    endtask

    // Monitor body: every memory write must match the head of the expectation queue.
    task automatic mon_step(input bit sel);
        obs_t o;
        wr_t  e;
        logic r;
        int   qs;
        o  = snap(sel);
        r  = sel ? rst2 : rst1;
        qs = sel ? exp_q2.size() : exp_q1.size();
        if (r) begin
            last_addr[sel] = 32'd0;
            last_data[sel] = 32'd0;
        end else if (o.we) begin
            if (qs == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write dut%0d: mem_we=1 addr=%h, required no write", sel + 1, o.addr);
            end else begin
                if (sel) e = exp_q2.pop_front();
                else     e = exp_q1.pop_front();
                check("mem_addr", o.addr, e.addr);
                check("mem_wdata", o.wdata, e.data);
                check("byte_ready_in_write", 32'(o.ready), 32'd0);
                check("mem_we_back_to_back", 32'(prev_we[sel]), 32'd0);
                last_addr[sel] = e.addr;
                last_data[sel] = e.data;
                $display("dut%0d write addr=%h data=%h (expected %h %h)", sel + 1, o.addr, o.wdata, e.addr, e.data);
            end
        end else begin
            check("mem_addr_hold", o.addr, last_addr[sel]);
            check("mem_wdata_hold", o.wdata, last_data[sel]);
        end
        prev_we[sel] = o.we;
    endtask

    initial begin
        prev_we[0] = 1'b0; prev_we[1] = 1'b0;
        last_addr[0] = 32'd0; last_addr[1] = 32'd0;
        last_data[0] = 32'd0; last_data[1] = 32'd0;
        forever begin
            @(negedge clk);
            mon_step(1'b0);
            mon_step(1'b1);
        end
    end

    // Called and returns just after a negedge; the byte transfers on the posedge in between.
    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        int   n;
        obs_t o;
        n = 0;
        drv(sel, 1'b0, 1'b1, b);
        o = snap(sel);
        while (!o.ready && n < 50) begin
            @(negedge clk);
            n++;
            o = snap(sel);
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout dut%0d: byte_ready stayed 0, required 1", sel + 1);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, b);
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset(input bit sel);
        #1;
        if (sel) begin rst2 = 1'b1; exp_q2.delete(); end
        else     begin rst1 = 1'b1; exp_q1.delete(); end
        @(negedge clk);
        check_reset_vals(sel);
        #1;
        if (sel) rst2 = 1'b0;
        else     rst1 = 1'b0;
        @(negedge clk);
    endtask

    // Reference model: word i of the image lands at base + 4*i (mod 2^32), then DONE.
    task automatic do_load(input bit sel, input int gap);
        logic [31:0] base;
        logic [31:0] w;
        logic [15:0] len;
        wr_t         e;
        obs_t        o;
        bit          last;
        base = sel ? BASE2 : BASE1;
        len  = 16'(img.size());
        for (int i = 0; i < img.size(); i++) begin
            e.addr = base + 32'(i) * 32'd4;
            e.data = img[i];
            if (sel) exp_q2.push_back(e);
            else     exp_q1.push_back(e);
        end
        $display("dut%0d load: %0d words, gap %0d", sel + 1, len, gap);
        drv(sel, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 8'h00);
        send_byte(sel, len[15:8], gap);
        drv(sel, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 8'h00);
        send_byte(sel, len[7:0], (len == 16'd0) ? 0 : gap);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                last = (i == img.size() - 1) && (k == 3);
                send_byte(sel, w[31 - 8 * k -: 8], last ? 0 : gap);
            end
        end
        o = snap(sel);
        if (len == 16'd0) begin
            check("load_done_after_header", 32'(o.done), 32'd1);
        end else begin
            check("load_done_in_write_cycle", 32'(o.done), 32'd0);
            @(negedge clk);
            o = snap(sel);
            check("load_done", 32'(o.done), 32'd1);
        end
        check("cpu_hold_done", 32'(o.hold), 32'd0);
        check("word_count", 32'(o.wc), 32'(len));
        check("pending_writes", sel ? 32'(exp_q2.size()) : 32'(exp_q1.size()), 32'd0);
    endtask

    initial begin
        obs_t o;
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        rst1 = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values, also while a byte is offered and no load_go arrives.
        drv(1'b0, 1'b0, 1'b1, 8'hA5);
        check_reset_vals(1'b0);
        check_reset_vals(1'b1);
        #1 rst1 = 1'b0; rst2 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_vals(1'b0);
        end
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);

        // Single word 8C22_0004, then load_go in DONE must be ignored.
        img.delete();
        img.push_back(32'h8C22_0004);
        do_load(1'b0, 0);
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        o = snap(1'b0);
        check("done_ignores_load_go", 32'(o.done), 32'd1);
        check("done_word_count", 32'(o.wc), 32'd1);

        // Three words without and with gaps, same data.
        img.delete();
        repeat (3) img.push_back($urandom());
        do_reset(1'b0);
        do_load(1'b0, 0);
        do_reset(1'b0);
        do_load(1'b0, 2);

        // Zero length: DONE right after the header, nothing accepted afterwards.
        do_reset(1'b0);
        img.delete();
        do_load(1'b0, 0);
        drv(1'b0, 1'b0, 1'b1, 8'h55);
        repeat (3) begin
            @(negedge clk);
            o = snap(1'b0);
            check("zero_len_byte_ready", 32'(o.ready), 32'd0);
        end
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        check("zero_len_word_count", 32'(o.wc), 32'd0);

        // Reset after two data bytes of word 1: immediate reset values, no write.
        do_reset(1'b0);
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(1'b0, 8'h00, 0);
        send_byte(1'b0, 8'h02, 0);
        send_byte(1'b0, 8'hAA, 0);
        send_byte(1'b0, 8'hBB, 0);
        #1 rst1 = 1'b1;
        #1 check_reset_vals(1'b0);
        @(negedge clk);
        check_reset_vals(1'b0);
        #1 rst1 = 1'b0;
        @(negedge clk);
        img.delete();
        repeat (2) img.push_back($urandom());
        do_load(1'b0, 1);

        // Random lengths, data and gap spacing.
        for (int t = 0; t < 6; t++) begin
            do_reset(1'b0);
            img.delete();
            repeat ($urandom_range(1, 6)) img.push_back($urandom());
            do_load(1'b0, $urandom_range(0, 3));
        end

        // Address wrap past 2^32 on the second instance.
        do_reset(1'b1);
        img.delete();
        repeat (2) img.push_back($urandom());
        do_load(1'b1, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
